ddr_tx_lane_array: RTL

- Parametrised multi-lane DDR transmit front end.
- Sits between core logic and per-lane O_DDR → O_BUFT_DS pairs, with clk taken from the clock I_BUF.
- Each lane carries 2 bits per clk; O_DDR serialises them.
- Generalises the single fixed-width DDR output path: lane count, output-enable sequencing, a link-training phase and a valid/ready input handshake.

---
 rtl/ddr_tx_lane_array.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr_tx_lane_array.sv
// ddr_tx_lane_array
//
// Multi-lane DDR transmit front end. It sits between core logic and the per-lane
// O_DDR -> O_BUFT_DS pairs. Each lane carries two bits per clk, and bit 2k leaves
// the wire first. Link bring-up runs IDLE -> WAKE -> TRAIN -> DATA. Shutdown runs
// DATA -> DRAIN -> IDLE. WAKE and DRAIN give the output buffers OE_DELAY cycles of
// settling around the live traffic.
//
// Optional feature: define TX_PRBS7_EN to replace the fixed training pattern with
// a per-lane PRBS7 (x^7 + x^6 + 1) stream.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset; it acts regardless of en
//   en          global clock enable; low freezes all state; also drives ddr_e
//   start       requests link bring-up while in IDLE
//   stop        requests shutdown while in DATA
//   in_data     2*NUM_CH bits; lane k uses [2k+1:2k]
//   in_valid    in_data is valid
//   in_ready    the block accepts in_data this cycle (combinational)
//   ddr_d       registered D pairs to the O_DDR instances
//   ddr_e       O_DDR enable, equal to en
//   oe          per-lane buffer enable; all bits identical
//   link_state  0 IDLE, 1 WAKE, 2 TRAIN, 3 DATA or DRAIN
//   train_done  high during the final TRAIN cycle; the next edge enters DATA
module ddr_tx_lane_array #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned TRAIN_LEN = 8,
  parameter int unsigned OE_DELAY  = 2,
  parameter logic [1:0]  TRAIN_PAT = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  input  logic [2*NUM_CH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*NUM_CH-1:0]   ddr_d,
  output logic                  ddr_e,
  output logic [NUM_CH-1:0]     oe,
  output logic [1:0]            link_state,
  output logic                  train_done
);

  localparam int unsigned CntMax = (TRAIN_LEN > OE_DELAY) ? TRAIN_LEN : OE_DELAY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] TrainLast = CntW'(TRAIN_LEN - 1);
  localparam logic [CntW-1:0] OeLast    = CntW'(OE_DELAY - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWake,
    StTrain,
    StData,
    StDrain
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [2*NUM_CH-1:0]   ddr_d_q;
  logic                  oe_q;
  logic [2*NUM_CH-1:0]   train_sym;
  logic                  xfer;

  assign ddr_e      = en;
  assign in_ready   = en & ~stop & (state_q == StData);
  assign xfer       = in_valid & in_ready;
  assign train_done = en & (state_q == StTrain) & (cnt_q == TrainLast);
  assign ddr_d      = ddr_d_q;
  assign oe         = {NUM_CH{oe_q}};

  always_comb begin
    link_state = 2'd0;
    unique case (state_q)
      StIdle:  link_state = 2'd0;
      StWake:  link_state = 2'd1;
      StTrain: link_state = 2'd2;
      StData:  link_state = 2'd3;
      StDrain: link_state = 2'd3;
      default: link_state = 2'd0;
    endcase
  end

`ifdef TX_PRBS7_EN
  // The LFSRs step on every edge that puts a training symbol on ddr_d. That
  // includes the WAKE -> TRAIN edge, which outputs symbol 0. Over a full TRAIN
  // phase each LFSR therefore advances exactly 2*TRAIN_LEN bits.
  logic emit_pat;
  logic reseed;

  assign emit_pat = ((state_q == StWake) && (cnt_q == OeLast)) ||
                    ((state_q == StTrain) && (cnt_q != TrainLast));
  assign reseed   = (state_q == StIdle) && start && !stop;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_prbs
    // 7'h7F + k wraps to 0 for k = 1. Zero is the LFSR lock-up state, so that
    // lane falls back to 7'h01.
    localparam int unsigned SeedRaw = (127 + k) % 128;
    localparam logic [6:0]  Seed    = (SeedRaw == 0) ? 7'h01 : 7'(SeedRaw);

    logic [6:0] lfsr_q;
    logic [6:0] step1;
    logic [6:0] step2;
    logic       bit0;
    logic       bit1;

    always_comb begin
      bit0  = lfsr_q[6] ^ lfsr_q[5];
      step1 = {lfsr_q[5:0], bit0};
      bit1  = step1[6] ^ step1[5];
      step2 = {step1[5:0], bit1};
    end

    assign train_sym[2*k+1:2*k] = {bit1, bit0};

    always_ff @(posedge clk) begin
      if (rst) begin
        lfsr_q <= Seed;
      end else if (en) begin
        if (reseed) begin
          lfsr_q <= Seed;
        end else if (emit_pat) begin
          lfsr_q <= step2;
        end
      end
    end
  end
`else
  assign train_sym = {NUM_CH{TRAIN_PAT}};
`endif

  // ddr_d and oe are registered together with the state. As a result oe
  // changes on the same edge as link_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ddr_d_q <= '0;
      oe_q    <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          ddr_d_q <= '0;
          oe_q    <= 1'b0;
          if (start && !stop) begin
            state_q <= StWake;
            cnt_q   <= '0;
            oe_q    <= 1'b1;
          end
        end
        StWake: begin
          if (cnt_q == OeLast) begin
            state_q <= StTrain;
            cnt_q   <= '0;
            ddr_d_q <= train_sym;
          end else begin
            cnt_q   <= cnt_q + CntOne;
            ddr_d_q <= '0;
          end
        end
        StTrain: begin
          if (cnt_q == TrainLast) begin
            state_q <= StData;
            cnt_q   <= '0;
            ddr_d_q <= '0;
          end else begin
            cnt_q   <= cnt_q + CntOne;
            ddr_d_q <= train_sym;
          end
        end
        StData: begin
          if (stop) begin
            // No transfer happens in the stop cycle because in_ready is low.
            state_q <= StDrain;
            cnt_q   <= '0;
            ddr_d_q <= '0;
          end else begin
            ddr_d_q <= xfer ? in_data : '0;
          end
        end
        StDrain: begin
          ddr_d_q <= '0;
          if (cnt_q == OeLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          ddr_d_q <= '0;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
